reaction_timer_ctrl: RTL and testbench
======================================

# reaction_timer_ctrl

Control FSM for the reaction-timer game, sitting directly upstream of the BCD display counter. Takes the two player push-buttons, waits a pseudo-random delay, lights the go LED, and drives the counter's `start` and `reset` inputs so the counter advances once per millisecond until the player reacts. Also detects false starts and the 9999 ms timeout.

## Interface
- `CLK_PER_MS`, default 50000: clock cycles per millisecond tick. Benches use 4.
- `MIN_DELAY_MS`, default 1000: minimum random wait.
- `MAX_MS`, default 9999: elapsed limit that matches the 4-digit display.
- `clock`, in, 1: system clock, 50 MHz.
- `reset`, in, 1: asynchronous, active-high. Clears all state immediately.
- `go_n`, in, 1: start button, active-low, asynchronous to `clock`.
- `stop_n`, in, 1: reaction button, active-low, asynchronous to `clock`.
- `count_en`, out, 1: drives counter `start`. One-cycle pulse per ms while RUNNING.
- `count_clr`, out, 1: drives counter `reset`.
- `led`, out, 1: go light. High only in RUNNING.
- `false_start`, out, 1: high in FALSE_START.
- `timeout`, out, 1: sticky high in DONE when the limit is reached.
- `elapsed_ms`, out, 14: internal ms count, mirrors the counter value.
- `state`, out, 3: current state, for debug LEDs.

## Operation
- Both buttons pass through a 2-FF synchronizer, then a falling-edge detector (previous synced value 1, current 0). A press yields one `go_p`/`stop_p` pulse; holding the button does nothing further.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1 on reset. Free-runs every cycle.
- States: IDLE=0, ARMED=1, RUNNING=2, DONE=3, FALSE_START=4.
- **IDLE / DONE / FALSE_START**
  - `go_p` → ARMED.
  - On entry to ARMED: `delay_ms` = MIN_DELAY_MS + lfsr[10:0] (range 1000–3047); `elapsed_ms`=0; `timeout`=0; `count_clr` pulsed for 1 cycle.
- **ARMED**
  - `stop_p` → FALSE_START.
  - Otherwise, `delay_ms` decrements on each ms tick. When a tick arrives with `delay_ms`==1 → RUNNING.
- **RUNNING**
  - `stop_p` → DONE.
  - Otherwise, on each tick: `count_en` pulses and `elapsed_ms` increments.
  - When a tick makes `elapsed_ms`==MAX_MS → DONE with `timeout`=1. `count_en` still pulses on that tick.
- Priority on simultaneous events:
  - `stop_p` beats tick: a stop in the same cycle as a tick produces no `count_en` and no increment.
  - `go_p` is ignored in ARMED and RUNNING.
  - If `go_p` and `stop_p` arrive together in IDLE/DONE/FALSE_START, go wins.
- Width rules:
  - `elapsed_ms` is 14-bit and never wraps; it saturates at MAX_MS through the transition to DONE.
  - `delay_ms` is 12-bit.
- ms prescaler:
  - Counts 0..CLK_PER_MS-1 and resets to 0 on every state change.
  - Tick asserts when the prescaler equals CLK_PER_MS-1, so the first tick comes CLK_PER_MS cycles after entering a state.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, `count_clr`=1, `count_en`=0, `led`=0, `false_start`=0, `timeout`=0, `elapsed_ms`=0, prescaler=0, LFSR=16'hACE1.
- `count_clr` stays 1 during reset and drops on the first `clock` edge after deassertion. This clears the synchronous-reset counter downstream.
- Button latency: a button low before edge k gives a state change and registered outputs at edge k+2.
- `led` rises on the same edge as entry to RUNNING. It falls on the same edge as exit from RUNNING.
- `count_en` and the `elapsed_ms` increment occur on the same edge, so `elapsed_ms` equals the downstream count.
- Reset mid-operation returns to the reset values at once, with no partial pulses.

## Structure
- Shared include `reaction_defs.vh` holds:
  - the state localparams;
  - the LFSR seed and taps;
  - the default MAX_MS.
- The downstream counter also uses MAX_MS.
- Sub-module `btn_edge_sync` (2-FF sync plus falling-edge pulse) is instantiated twice.
- The LFSR, prescaler and FSM stay inline.

## Test plan
- **Reset release:** assert `reset` for 3 cycles, then deassert. Expect state=0 and `count_clr`=1 until the first edge after release, then 0. All other outputs 0.
- **Normal run** (CLK_PER_MS=4, force LFSR low bits=0):
  - Press `go_n`. Expect ARMED 2 edges later and a 1-cycle `count_clr`.
  - RUNNING and `led`=1 follow after 1000 ticks (4000 cycles).
  - Press `stop_n` after 250 ticks. Expect DONE, `elapsed_ms`=250, exactly 250 `count_en` pulses, `led`=0.
- **False start:** press `stop_n` during ARMED. Expect FALSE_START, `false_start`=1, `led` never asserted, no `count_en`.
- **Timeout:** in RUNNING with no stop, expect DONE after 9999 ticks with `timeout`=1 and `elapsed_ms`=9999. A new `go_n` press clears `timeout`.
- **Simultaneous events:**
  - `stop_p` coincident with a tick: no increment.
  - Holding `stop_n` low across re-arm: no second stop event.
  - Pressing `go_n` during RUNNING: ignored.
- **Mid-run reset:** assert `reset` in RUNNING. Outputs return to reset values on that edge, asynchronously, without waiting for `clock`.

Source files
------------

// File: rtl/reaction_timer_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// reaction_timer_ctrl_pkg
// Shared definitions for the reaction-timer controller and the downstream BCD
// display counter: state encodings, LFSR seed/taps and the default elapsed
// limit that matches the 4-digit display.
// ---------------------------------------------------------------------------
package reaction_timer_ctrl_pkg;

  // State encodings, also exported on the debug 'state' port.
  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_ARMED       = 3'd1;
  localparam logic [2:0] ST_RUNNING     = 3'd2;
  localparam logic [2:0] ST_DONE        = 3'd3;
  localparam logic [2:0] ST_FALSE_START = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE        = ST_IDLE,
    S_ARMED       = ST_ARMED,
    S_RUNNING     = ST_RUNNING,
    S_DONE        = ST_DONE,
    S_FALSE_START = ST_FALSE_START
  } state_t;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bit indices 15,13,12,10).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'b1011_0100_0000_0000;

  // Largest value the 4-digit display can show.
  localparam int MAX_MS_DEFAULT = 9999;

  // One LFSR step: shift left, feedback is the XOR of the tapped bits.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/reaction_timer_ctrl_btn_edge_sync.sv
// ---------------------------------------------------------------------------
// btn_edge_sync
// Brings an active-low push-button into the clock domain with a 2-FF
// synchronizer and emits a single-cycle pulse on each press (synced value
// going 1 -> 0). Holding the button produces no further pulses.
// Ports:
//   clock  - system clock
//   reset  - asynchronous active-high reset (button treated as released)
//   btn_n  - raw active-low button, asynchronous to clock
//   press  - one-cycle pulse per press
// ---------------------------------------------------------------------------
module btn_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  // Resetting to 1 (released) keeps a button held through reset from
  // looking like a fresh press afterwards.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      prev_p2 <= 1'b1;
    end else begin
      // stage 0: metastability capture
      sync_p0 <= btn_n;
      // stage 1: synchronized level
      sync_p1 <= sync_p0;
      // stage 2: previous synchronized level for edge detection
      prev_p2 <= sync_p1;
    end
  end

  assign press = prev_p2 & ~sync_p1;

endmodule

// File: rtl/reaction_timer_ctrl.sv
// ---------------------------------------------------------------------------
// reaction_timer_ctrl
// Control FSM for the reaction-timer game. Waits a pseudo-random delay after
// the go button, lights the go LED and drives the downstream BCD counter
// (count_en = counter start, count_clr = counter reset) once per millisecond
// until the player presses stop. Detects false starts and the display limit.
// Ports:
//   clock, reset         - system clock, asynchronous active-high reset
//   go_n, stop_n         - raw active-low buttons
//   count_en             - one-cycle pulse per ms while RUNNING
//   count_clr            - clears the downstream counter (1 during reset,
//                          one-cycle pulse on entry to ARMED)
//   led                  - go light, high only in RUNNING
//   false_start          - high in FALSE_START
//   timeout              - sticky in DONE when the limit was reached
//   elapsed_ms[13:0]     - internal ms count, mirrors the downstream counter
//   state[2:0]           - current state for debug LEDs
// ---------------------------------------------------------------------------
module reaction_timer_ctrl
  import reaction_timer_ctrl_pkg::*;
#(
  parameter int CLK_PER_MS   = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int MAX_MS       = MAX_MS_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        go_n,
  input  logic        stop_n,
  output logic        count_en,
  output logic        count_clr,
  output logic        led,
  output logic        false_start,
  output logic        timeout,
  output logic [13:0] elapsed_ms,
  output logic [2:0]  state
);

  localparam int            PW         = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);
  localparam logic [13:0]   MAX_W      = 14'(MAX_MS);
  localparam logic [11:0]   MIN_W      = 12'(MIN_DELAY_MS);

  state_t        state_q;
  logic [15:0]   lfsr;
  logic [PW-1:0] presc;
  logic [11:0]   delay_ms;
  logic          go_p;
  logic          stop_p;
  logic          tick;

  // Elapsed count never wraps; it holds at the display limit.
  function automatic logic [13:0] sat_inc(input logic [13:0] v);
    return (v >= MAX_W) ? MAX_W : v + 14'd1;
  endfunction

  btn_edge_sync u_go_sync (
    .clock (clock),
    .reset (reset),
    .btn_n (go_n),
    .press (go_p)
  );

  btn_edge_sync u_stop_sync (
    .clock (clock),
    .reset (reset),
    .btn_n (stop_n),
    .press (stop_p)
  );

  assign tick  = (presc == PRESC_LAST);
  assign state = state_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lfsr        <= LFSR_SEED;
      presc       <= '0;
      delay_ms    <= '0;
      elapsed_ms  <= '0;
      count_en    <= 1'b0;
      count_clr   <= 1'b1;
      led         <= 1'b0;
      false_start <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      lfsr      <= lfsr_step(lfsr);
      count_en  <= 1'b0;
      count_clr <= 1'b0;
      // Free-running ms prescaler; every state change below restarts it so
      // the first tick lands CLK_PER_MS cycles after entry.
      presc     <= tick ? '0 : presc + PW'(1);

      case (state_q)
        S_IDLE, S_DONE, S_FALSE_START: begin
          // go wins over a coincident stop here simply by being the only
          // event these states react to.
          if (go_p) begin
            state_q     <= S_ARMED;
            presc       <= '0;
            delay_ms    <= MIN_W + {1'b0, lfsr[10:0]};
            elapsed_ms  <= '0;
            timeout     <= 1'b0;
            false_start <= 1'b0;
            count_clr   <= 1'b1;
          end
        end

        S_ARMED: begin
          if (stop_p) begin
            state_q     <= S_FALSE_START;
            presc       <= '0;
            false_start <= 1'b1;
          end else if (tick) begin
            // <=1 also covers a zero delay if MIN_DELAY_MS is set to 0.
            if (delay_ms <= 12'd1) begin
              state_q <= S_RUNNING;
              presc   <= '0;
              led     <= 1'b1;
            end else begin
              delay_ms <= delay_ms - 12'd1;
            end
          end
        end

        S_RUNNING: begin
          // stop takes priority over a same-cycle tick: no pulse, no increment.
          if (stop_p) begin
            state_q <= S_DONE;
            presc   <= '0;
            led     <= 1'b0;
          end else if (tick) begin
            count_en   <= 1'b1;
            elapsed_ms <= sat_inc(elapsed_ms);
            if (sat_inc(elapsed_ms) == MAX_W) begin
              state_q <= S_DONE;
              presc   <= '0;
              led     <= 1'b0;
              timeout <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          presc   <= '0;
          led     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reaction_timer_ctrl
// Scoreboard bench: each stimulus step pushes the expected state transition
// (state, outputs, count_en pulses since arming, edge number) into a queue;
// a monitor pops and compares whenever the DUT changes state.
// ---------------------------------------------------------------------------
module tb_reaction_timer_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        go_n = 1'b1;
  logic        stop_n = 1'b1;
  logic        count_en;
  logic        count_clr;
  logic        led;
  logic        false_start;
  logic        timeout;
  logic [13:0] elapsed_ms;
  logic [2:0]  state;

  reaction_timer_ctrl #(.CLK_PER_MS(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .go_n        (go_n),
    .stop_n      (stop_n),
    .count_en    (count_en),
    .count_clr   (count_clr),
    .led         (led),
    .false_start (false_start),
    .timeout     (timeout),
    .elapsed_ms  (elapsed_ms),
    .state       (state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  st;
    logic [13:0] el;
    logic        led;
    logic        fs;
    logic        to;
    logic        clr;
    int          en;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   led_bad = 0;
  int   clr_bad = 0;
  logic [15:0] l_m;

  // Reference LFSR: taps 16,14,13,11 written out bit by bit.
  function automatic logic [15:0] nxt(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock or posedge reset) begin
    if (reset) l_m <= 16'hACE1;
    else       l_m <= nxt(l_m);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input logic [2:0] st, input int el, input logic ld, input logic fs,
                      input logic to, input logic clr, input int en, input int c);
    exp_t e;
    e.st = st; e.el = 14'(el); e.led = ld; e.fs = fs; e.to = to;
    e.clr = clr; e.en = en; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  // Presses go at a negedge chosen so the LFSR value sampled on entry to
  // ARMED has small low bits (keeps each wait near 1000 ms).
  task automatic arm_press(output int n, output int d);
    logic [15:0] p;
    int tries;
    tries = 0;
    @(negedge clock);
    p = nxt(nxt(l_m));
    while (p[10:0] >= 11'd64 && tries < 5000) begin
      @(negedge clock);
      p = nxt(nxt(l_m));
      tries++;
    end
    check("lfsr_wait", 32'(tries < 5000), 32'd1);
    go_n = 1'b0;
    n = cyc;
    d = 1000 + int'(p[10:0]);
  endtask

  // Monitor: compares every state transition against the queue head.
  initial begin : monitor
    logic [2:0] prev_state;
    int en_run;
    exp_t e;
    prev_state = 3'd0;
    en_run = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_state = 3'd0;
        en_run = 0;
      end else begin
        if (count_clr) en_run = 0;
        if (count_en) en_run++;
        if (led !== (state == 3'd2)) led_bad++;
        if (count_clr !== ((state != prev_state) && (state == 3'd1))) clr_bad++;
        if (state != prev_state) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_transition actual=%0d required=none cyc=%0d", state, cyc);
          end else begin
            e = q.pop_front();
            check("tr_state", 32'(state), 32'(e.st));
            check("tr_cycle", 32'(cyc), 32'(e.cyc));
            check("tr_elapsed", 32'(elapsed_ms), 32'(e.el));
            check("tr_led", 32'(led), 32'(e.led));
            check("tr_false_start", 32'(false_start), 32'(e.fs));
            check("tr_timeout", 32'(timeout), 32'(e.to));
            check("tr_count_clr", 32'(count_clr), 32'(e.clr));
            check("tr_count_en_pulses", 32'(en_run), 32'(e.en));
          end
        end
        prev_state = state;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n, d, e, r;

    // Reset release
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_state", 32'(state), 32'd0);
    check("rst_count_clr", 32'(count_clr), 32'd1);
    check("rst_count_en", 32'(count_en), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_false_start", 32'(false_start), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_elapsed", 32'(elapsed_ms), 32'd0);
    reset = 1'b0;
    #1;
    check("rel_count_clr_held", 32'(count_clr), 32'd1);
    @(negedge clock);
    check("rel_count_clr_drop", 32'(count_clr), 32'd0);
    check("rel_state", 32'(state), 32'd0);

    // Normal run: stop after 250 ticks; go pressed during RUNNING is ignored.
    arm_press(n, d);
    e = n + 3;
    r = e + 4 * d;
    push(3'd1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0, e);
    push(3'd2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, r);
    repeat (5) @(negedge clock);
    go_n = 1'b1;
    wait_until(r + 100);
    go_n = 1'b0;
    repeat (3) @(negedge clock);
    go_n = 1'b1;
    wait_until(r + 999);
    stop_n = 1'b0;
    push(3'd3, 250, 1'b0, 1'b0, 1'b0, 1'b0, 250, r + 1002);
    wait_until(r + 1004);

    // stop_n still held across re-arm; then a stop coincident with tick 5.
    arm_press(n, d);
    e = n + 3;
    r = e + 4 * d;
    push(3'd1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0, e);
    push(3'd2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, r);
    repeat (5) @(negedge clock);
    go_n = 1'b1;
    wait_until(e + 10);
    stop_n = 1'b1;
    wait_until(r + 17);
    stop_n = 1'b0;
    push(3'd3, 4, 1'b0, 1'b0, 1'b0, 1'b0, 4, r + 20);
    wait_until(r + 22);
    stop_n = 1'b1;
    repeat (5) @(negedge clock);

    // go and stop together in DONE (go wins), then a false start.
    @(negedge clock);
    go_n = 1'b0;
    stop_n = 1'b0;
    n = cyc;
    push(3'd1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0, n + 3);
    wait_until(n + 5);
    go_n = 1'b1;
    stop_n = 1'b1;
    wait_until(n + 10);
    stop_n = 1'b0;
    push(3'd4, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, n + 13);
    wait_until(n + 15);
    stop_n = 1'b1;
    repeat (5) @(negedge clock);

    // Timeout at 9999 ms.
    arm_press(n, d);
    e = n + 3;
    r = e + 4 * d;
    push(3'd1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0, e);
    push(3'd2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, r);
    push(3'd3, 9999, 1'b0, 1'b0, 1'b1, 1'b0, 9999, r + 4 * 9999);
    repeat (5) @(negedge clock);
    go_n = 1'b1;
    wait_until(r + 4 * 9999 + 3);

    // New go clears timeout; then reset mid-run.
    arm_press(n, d);
    e = n + 3;
    r = e + 4 * d;
    push(3'd1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0, e);
    push(3'd2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, r);
    repeat (5) @(negedge clock);
    go_n = 1'b1;
    wait_until(r + 30);
    check("pre_rst_elapsed", 32'(elapsed_ms), 32'd7);
    check("pre_rst_led", 32'(led), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_count_clr", 32'(count_clr), 32'd1);
    check("mid_rst_count_en", 32'(count_en), 32'd0);
    check("mid_rst_led", 32'(led), 32'd0);
    check("mid_rst_false_start", 32'(false_start), 32'd0);
    check("mid_rst_timeout", 32'(timeout), 32'd0);
    check("mid_rst_elapsed", 32'(elapsed_ms), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    check("queue_drained", 32'(q.size()), 32'd0);
    check("led_vs_state_cycles", 32'(led_bad), 32'd0);
    check("clr_pulse_cycles", 32'(clr_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
